// File: rtl/vproj_pkg.sv
// Shared definitions for the projection-weight loaders and SRAM wrappers.
package vproj_pkg;

   localparam int unsigned VPROJ_DEPTH  = 128;
   localparam int unsigned VPROJ_ADDR_W = 7;
   localparam int unsigned VPROJ_ROW_W  = 128;
   localparam int unsigned FP32_W       = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      FIN   = 2'd3
   } loader_state_t;

endpackage

// File: rtl/vproj_mem_loader_row_packer.sv
// row_packer: assembles WPR words of WORD_W bits into one ROW_W-bit row.
// Word lane k occupies row[WORD_W*k +: WORD_W]; lane 0 sits in the LSBs.
// Shared by the K/Q/V projection loaders.
module row_packer #(
   parameter int unsigned ROW_W  = 128,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned WPR    = ROW_W / WORD_W,
   parameter int unsigned LANE_W = $clog2(WPR)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [LANE_W-1:0] lane,
   input  logic [WORD_W-1:0] word,
   output logic [ROW_W-1:0]  row
);

   // Insert the incoming word into its lane; clear discards a partial row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
      end else if (clear) begin
         row <= '0;
      end else if (load) begin
         for (int unsigned i = 0; i < WPR; i++) begin
            if (lane == LANE_W'(i)) begin
               row[i*WORD_W +: WORD_W] <= word;
            end
         end
      end
   end

endmodule

// File: rtl/vproj_mem_loader.sv
// vproj_mem_loader: write-side master for the V-projection weight SRAM init
// port. Packs WPR input words per row, writes rows 0..DEPTH-1 in order and
// pulses done after the last row. init_en is held while a load is running so
// the SRAM address mux stays on the init port.
module vproj_mem_loader
   import vproj_pkg::*;
#(
   parameter int unsigned DEPTH  = VPROJ_DEPTH,
   parameter int unsigned ADDR_W = VPROJ_ADDR_W,
   parameter int unsigned ROW_W  = VPROJ_ROW_W,
   parameter int unsigned WORD_W = FP32_W,
   parameter int unsigned WPR    = ROW_W / WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              init_en,
   output logic              init_we_n,
   output logic [ADDR_W-1:0] init_addr,
   output logic [ROW_W-1:0]  init_din,
   output logic              busy,
   output logic              done
);

   localparam int unsigned LANE_W = $clog2(WPR);

   if (ADDR_W != $clog2(DEPTH)) begin : g_chk_addr
      $error("vproj_mem_loader: ADDR_W must equal clog2(DEPTH)");
   end
   if (WPR * WORD_W != ROW_W) begin : g_chk_wpr
      $error("vproj_mem_loader: WPR must equal ROW_W/WORD_W");
   end

   loader_state_t     state;
   logic [ADDR_W-1:0] row_cnt;
   logic [LANE_W-1:0] word_cnt;
   logic              we_n_q;
   logic              accept;
   logic              last_beat;
   logic              last_row;
   logic              pk_load;
   logic              pk_clear;

   // Beat handshake and packer control.
   always_comb begin
      accept    = in_valid & in_ready;
      last_beat = (word_cnt == LANE_W'(WPR - 1));
      last_row  = (row_cnt == ADDR_W'(DEPTH - 1));
      pk_load   = (state == FILL) & accept & ~abort;
      pk_clear  = abort & ((state == FILL) | (state == WRITE));
   end

   // Row assembly register; its output is the registered init_din.
   row_packer #(
      .ROW_W  (ROW_W),
      .WORD_W (WORD_W),
      .WPR    (WPR),
      .LANE_W (LANE_W)
   ) u_row_packer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pk_load),
      .clear (pk_clear),
      .lane  (word_cnt),
      .word  (in_data),
      .row   (init_din)
   );

   // Control FSM; every output register is loaded with its next-state value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row_cnt   <= '0;
         word_cnt  <= '0;
         in_ready  <= 1'b0;
         init_en   <= 1'b0;
         we_n_q    <= 1'b1;
         init_addr <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done   <= 1'b0;
         we_n_q <= 1'b1;
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  state    <= FILL;
                  row_cnt  <= '0;
                  word_cnt <= '0;
                  in_ready <= 1'b1;
                  init_en  <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            FILL: begin
               if (abort) begin
                  state    <= IDLE;
                  word_cnt <= '0;
                  in_ready <= 1'b0;
                  init_en  <= 1'b0;
                  busy     <= 1'b0;
               end else if (accept) begin
                  if (last_beat) begin
                     state     <= WRITE;
                     word_cnt  <= '0;
                     in_ready  <= 1'b0;
                     we_n_q    <= 1'b0;
                     init_addr <= row_cnt;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            WRITE: begin
               if (abort) begin
                  state    <= IDLE;
                  word_cnt <= '0;
                  in_ready <= 1'b0;
                  init_en  <= 1'b0;
                  busy     <= 1'b0;
               end else if (last_row) begin
                  state   <= FIN;
                  init_en <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  state    <= FILL;
                  row_cnt  <= row_cnt + 1'b1;
                  in_ready <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The write strobe is registered, but an abort arriving in the WRITE cycle
   // itself must still cancel that write, so abort gates it directly.
   assign init_we_n = we_n_q | abort;

endmodule

// File: tb/tb_vproj_mem_loader.sv
// Directed testbench for vproj_mem_loader with a behavioural 2-cycle-latency
// SRAM model on the init port.
module tb_vproj_mem_loader;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         in_ready;
   logic         init_en;
   logic         init_we_n;
   logic [6:0]   init_addr;
   logic [127:0] init_din;
   logic         busy;
   logic         done;

   vproj_mem_loader #(
      .DEPTH  (128),
      .ADDR_W (7),
      .ROW_W  (128),
      .WORD_W (32),
      .WPR    (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .init_en   (init_en),
      .init_we_n (init_we_n),
      .init_addr (init_addr),
      .init_din  (init_din),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int s_cyc  = 0;

   // stream source: word n = 0x3F800000 + n, n = accepted beats since prep
   logic mon_clr, beat_clr;
   int   beat_idx = 0;
   assign in_data = 32'h3F80_0000 + 32'(beat_idx);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (beat_clr) beat_idx <= 0;
      else if (in_valid && in_ready) beat_idx <= beat_idx + 1;
   end

   function automatic logic [127:0] exp_row(input int r);
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[32*k +: 32] = 32'h3F80_0000 + 32'(4*r + k);
      return v;
   endfunction

   // SRAM model and write monitor
   logic [127:0] mem [0:127];
   logic [6:0]   rd_addr;
   logic [127:0] rd_p1, rd_dout;
   int wr_cnt, order_bad, early_bad, data_bad, weq_bad, row10_wr;
   int done_cnt, done_cyc, beats;

   always @(posedge clk) begin
      rd_p1   <= mem[rd_addr];
      rd_dout <= rd_p1;
   end

   always @(negedge clk) begin
      if (mon_clr) begin
         wr_cnt = 0; order_bad = 0; early_bad = 0; data_bad = 0; weq_bad = 0;
         row10_wr = 0; done_cnt = 0; done_cyc = 0; beats = 0;
      end else begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (!init_we_n) begin
            if (!init_en) weq_bad++;
            if (init_addr !== 7'(wr_cnt)) order_bad++;
            if (beats != 4) early_bad++;
            if (init_din !== exp_row(int'(init_addr))) data_bad++;
            if (init_addr == 7'd10) row10_wr++;
            mem[init_addr] = init_din;
            wr_cnt++;
            beats = 0;
         end
         if (in_valid && in_ready) beats++;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic prep;
      mon_clr  = 1'b1;
      beat_clr = 1'b1;
      tick;
      mon_clr  = 1'b0;
      beat_clr = 1'b0;
   endtask

   task automatic start_load;
      start = 1'b1;
      s_cyc = cyc;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int i = 0;
      while (done_cnt == 0 && i < bound) begin
         tick;
         i++;
      end
      repeat (4) tick;
   endtask

   task automatic chk_load(input string tag);
      chk({tag, "_wr_cnt"},  128'(wr_cnt),    128'd128);
      chk({tag, "_order"},   128'(order_bad), 128'd0);
      chk({tag, "_early"},   128'(early_bad), 128'd0);
      chk({tag, "_data"},    128'(data_bad),  128'd0);
      chk({tag, "_we_no_en"},128'(weq_bad),   128'd0);
      chk({tag, "_done_cnt"},128'(done_cnt),  128'd1);
      chk({tag, "_busy"},    128'(busy),      128'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  128'(in_ready),  128'd0);
      chk({tag, "_init_en"},   128'(init_en),   128'd0);
      chk({tag, "_init_we_n"}, 128'(init_we_n), 128'd1);
      chk({tag, "_init_addr"}, 128'(init_addr), 128'd0);
      chk({tag, "_init_din"},  init_din,        128'd0);
      chk({tag, "_busy"},      128'(busy),      128'd0);
      chk({tag, "_done"},      128'(done),      128'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      rd_addr = '0; mon_clr = 1'b1; beat_clr = 1'b1;
      repeat (3) tick;
      chk_reset_vals("reset");
      rst_n = 1'b1;
      tick;

      // full load, in_valid held high
      prep;
      in_valid = 1'b1;
      start_load;
      wait_done(700);
      chk_load("full");
      chk("full_done_latency", 128'(done_cyc - s_cyc), 128'd641);
      chk("full_row5", mem[5], 128'h3F800017_3F800016_3F800015_3F800014);

      // backpressure: random gaps of 0..7 cycles before each beat
      prep;
      in_valid = 1'b0;
      start_load;
      for (int b = 0; b < 512; b++) begin
         int guard;
         in_valid = 1'b0;
         repeat (int'($urandom_range(7, 0))) tick;
         in_valid = 1'b1;
         guard = 0;
         while (in_ready !== 1'b1 && guard < 20) begin
            tick;
            guard++;
         end
         tick;
      end
      in_valid = 1'b0;
      wait_done(50);
      chk_load("bp");

      // abort during row 10 WRITE cycle (start cycle + 55)
      prep;
      in_valid = 1'b1;
      start_load;
      repeat (54) tick;
      chk("abort_pre_write", 128'(init_we_n), 128'd0);
      abort = 1'b1;
      #1;
      chk("abort_we_suppressed", 128'(init_we_n), 128'd1);
      tick;
      abort = 1'b0;
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_init_en", 128'(init_en), 128'd0);
      repeat (10) tick;
      chk("abort_row10_wr", 128'(row10_wr), 128'd0);
      chk("abort_wr_cnt", 128'(wr_cnt), 128'd10);
      chk("abort_no_done", 128'(done_cnt), 128'd0);
      prep;
      start_load;
      wait_done(700);
      chk_load("reload");

      // start pulses during row 3 WRITE, row 64 WRITE and FIN
      prep;
      start_load;
      repeat (19) tick;
      start = 1'b1; tick; start = 1'b0;
      repeat (304) tick;
      start = 1'b1; tick; start = 1'b0;
      repeat (315) tick;
      chk("sb_done_in_fin", 128'(done), 128'd1);
      start = 1'b1; tick; start = 1'b0;
      repeat (5) tick;
      chk_load("sb");
      chk("sb_done_latency", 128'(done_cyc - s_cyc), 128'd641);
      chk("sb_idle_in_ready", 128'(in_ready), 128'd0);

      // asynchronous reset during row 40 FILL (start cycle + 202)
      prep;
      start_load;
      repeat (201) tick;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      prep;
      start_load;
      wait_done(700);
      chk_load("postrst");

      // read back the last row through the 2-cycle read path
      rd_addr = 7'd127;
      tick;
      tick;
      chk("int_rd_127", rd_dout, exp_row(127));
      chk("int_din_hold", init_din, exp_row(127));
      chk("int_addr_hold", 128'(init_addr), 128'd127);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
